// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side stream blocks.
//   dsz_state_t   : stream_downsizer control state (IDLE / SHIFT).
//   dsz_ratio_ok  : elaboration-time check of an IN/OUT width pair.
package fifo_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } dsz_state_t;

    // A width pair is usable when the input word splits into a whole
    // number of output beats and there are at least two of them.
    function automatic bit dsz_ratio_ok(input int in_w, input int out_w);
        if (out_w <= 0) return 1'b0;
        return ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
    endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Width-converting stage: takes IN_WIDTH-bit words on a valid/ready
// handshake and emits each as RATIO OUT_WIDTH-bit beats, least-significant
// slice first. A new word is taken on the same cycle the last beat of the
// previous one leaves, so a continuous stream has no bubbles.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_data    input word (from the upstream FIFO out_data)
//   in_valid   input word valid
//   in_ready   block can take a word this cycle
//   out_data   current output beat
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   clear      synchronous flush, overrides every other event
//   busy       a word is held and not yet fully emitted
import fifo_pkg::*;

module stream_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
    parameter int LB_RATIO  = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 clear,
    output logic                 busy
);

    if (!dsz_ratio_ok(IN_WIDTH, OUT_WIDTH) || (RATIO != IN_WIDTH / OUT_WIDTH)) begin : g_bad_ratio
        $error("stream_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end

    localparam logic [LB_RATIO-1:0] LAST_BEAT = LB_RATIO'(RATIO - 1);

    dsz_state_t          state, state_d;
    logic [LB_RATIO-1:0] beat_cnt, beat_cnt_d;
    logic [IN_WIDTH-1:0] hold_r;
    logic                load;
    logic                last_beat;
    logic                in_exec;
    logic                out_exec;

    assign last_beat = (beat_cnt == LAST_BEAT);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == SHIFT);

    // in_ready looks at out_ready only when the last beat is leaving, and
    // never at in_valid, so no combinational loop forms with the upstream.
    assign in_ready  = ~clear & ((state == IDLE) | ((state == SHIFT) & last_beat & out_ready));
    assign in_exec   = in_valid & in_ready;
    assign out_exec  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            beat_cnt <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        beat_cnt_d = beat_cnt;
        load       = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_exec) begin
                        load       = 1'b1;
                        beat_cnt_d = '0;
                        state_d    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_exec) begin
                        if (!last_beat) begin
                            beat_cnt_d = beat_cnt + LB_RATIO'(1);
                        end else if (in_exec) begin
                            // back-to-back: next word replaces the one just finished
                            load       = 1'b1;
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d = '0;
                            state_d    = IDLE;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_r <= '0;
        end else if (load) begin
            hold_r <= in_data;
        end
    end

    // Slice mux; driven to zero outside SHIFT so an idle bus carries no stale data.
    always_comb begin
        out_data = '0;
        if (state == SHIFT) begin
            for (int i = 0; i < RATIO; i++) begin
                if (beat_cnt == LB_RATIO'(i)) begin
                    out_data = hold_r[i*OUT_WIDTH +: OUT_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
module tb_stream_downsizer;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int NB = IW / OW;

    logic          clk = 1'b0;
    logic          rstn;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          clear;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference model: beats still owed to the consumer, oldest first.
    logic [OW-1:0] owed[$];
    // Beats actually taken from the DUT, for end-of-test comparison.
    logic [OW-1:0] seen[$];
    bit            last_acc;

    stream_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .clear    (clear),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model,
    // then advance the model by what the handshakes should do at the edge.
    task automatic cycle(input logic iv, input logic [IW-1:0] id, input logic ordy, input logic clr);
        logic exp_ir;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        clear     = clr;
        #1;
        // Free to take a word when nothing is owed, or when the final owed
        // beat is leaving right now; never during a flush.
        exp_ir = !clr && ((owed.size() == 0) || (owed.size() == 1 && ordy));
        check("in_ready",  in_ready,  exp_ir);
        check("out_valid", out_valid, owed.size() != 0);
        check("busy",      busy,      owed.size() != 0);
        if (owed.size() != 0) check("out_data", out_data, owed[0]);
        last_acc = 1'b0;
        if (out_valid && ordy) seen.push_back(out_data);
        if (clr) begin
            owed.delete();
        end else begin
            if (owed.size() != 0 && ordy) void'(owed.pop_front());
            if (iv && exp_ir) begin
                last_acc = 1'b1;
                for (int b = 0; b < NB; b++) owed.push_back(id[b*OW +: OW]);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic expect_seen(input string tag, input logic [OW-1:0] exp[$]);
        check({tag, "_count"}, seen.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            if (k < seen.size()) check($sformatf("%s_beat%0d", tag, k), seen[k], exp[k]);
        end
        seen.delete();
    endtask

    initial begin
        logic [IW-1:0] words[$];
        logic [IW-1:0] fifo[$];
        int            cyc;

        rstn = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_out_data",  out_data,  '0);
        check("rst_in_ready",  in_ready,  1'b1);

        // 1: single word, LS byte first, idle afterwards
        cycle(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0);
        idle_cycles(5);
        expect_seen("single", '{8'hAA, 8'hBB, 8'hCC, 8'hDD});

        // 2: back-to-back words with in_valid held
        cycle(1'b1, 32'h03020100, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'h07060504, 1'b1, 1'b0);
        check("b2b_second_taken", last_acc, 1'b1);
        idle_cycles(5);
        expect_seen("b2b", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07});

        // 3: backpressure on beat 1, upstream keeps offering a word
        cycle(1'b1, 32'h44332211, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'hBAD0BAD0, 1'b0, 1'b0);
        check("stall_data", out_data, 8'h22);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        idle_cycles(2);
        expect_seen("stall", '{8'h11, 8'h22, 8'h33, 8'h44});

        // 4: clear on beat 2 with a new word waiting
        cycle(1'b1, 32'hA3A2A1A0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 32'h000000FF, 1'b0, 1'b1);
        check("clear_no_accept", last_acc, 1'b0);
        cycle(1'b1, 32'h000000FF, 1'b1, 1'b0);
        check("clear_then_accept", last_acc, 1'b1);
        idle_cycles(5);
        expect_seen("clear", '{8'hA0, 8'hA1, 8'hFF, 8'h00, 8'h00, 8'h00});

        // 5: asynchronous reset between edges while on beat 1
        cycle(1'b1, 32'h5A6B7C8D, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_busy",      busy,      1'b0);
        owed.delete();
        @(negedge clk);
        #1 rstn = 1'b1;
        idle_cycles(4);
        expect_seen("arst", '{8'h8D});

        // 6: random FIFO-fed stream with random backpressure
        for (int k = 0; k < 256; k++) begin
            words.push_back($urandom);
        end
        fifo = words;
        cyc = 0;
        while ((fifo.size() != 0 || owed.size() != 0) && cyc < 20000) begin
            logic iv;
            iv = (fifo.size() != 0) && ($urandom_range(0, 3) != 0);
            cycle(iv, iv ? fifo[0] : IW'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
            if (last_acc) void'(fifo.pop_front());
            cyc++;
        end
        check("rand_drained", cyc < 20000, 1'b1);
        check("rand_beats", seen.size(), 256 * NB);
        for (int w = 0; w < 256; w++) begin
            logic [IW-1:0] got;
            got = '0;
            for (int b = 0; b < NB; b++) begin
                if (w * NB + b < seen.size()) got[b*OW +: OW] = seen[w*NB + b];
            end
            check($sformatf("rand_word%0d", w), got, words[w]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
